// File: rtl/entrada_pkg.sv
// Shared types and helpers for the keypad-entry / timebase block.
package entrada_pkg;

  typedef enum logic {IDLE, HELD} state_e;

  // Widest keypad the helper functions accept; narrower vectors are zero-extended.
  localparam int MAX_KEYS = 32;

  // Bits needed to hold values 0..value-1 (never less than 1).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  function automatic logic is_onehot(input logic [MAX_KEYS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_KEYS; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

  function automatic logic [7:0] onehot_to_bin(input logic [MAX_KEYS-1:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (v[i]) r = r | 8'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a candidate/stability counter debouncer.
module key_debounce
  import entrada_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] candidate,
  output logic             stable
);

  localparam int               CNT_W   = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign candidate = cand_q;
  assign stable    = (cnt_q == CNT_MAX);

endmodule

// File: rtl/entrada_clock_param.sv
// Keypad accept FSM with one-shot active-low load strobe, plus seconds-tick divider.
module entrada_clock_param
  import entrada_pkg::*;
#(
  parameter int N_KEYS          = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CLK_DIV         = 100,
  parameter int TICK_MODE       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keyboard,
  input  logic              enablen,
  output logic [CODE_W-1:0] D,
  output logic              loadn,
  output logic              p_tick
);

  localparam int                TICK_W    = clog2(CLK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);

  logic [N_KEYS-1:0]   cand;
  logic                stable;
  logic [MAX_KEYS-1:0] cand_ext;
  logic                key_any, key_onehot, key_multi;
  logic [CODE_W-1:0]   key_code;

  key_debounce #(
    .WIDTH          (N_KEYS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .din      (keyboard),
    .candidate(cand),
    .stable   (stable)
  );

  always_comb begin
    cand_ext             = '0;
    cand_ext[N_KEYS-1:0] = cand;
    key_any              = |cand;
    key_onehot           = is_onehot(cand_ext);
    key_multi            = key_any && !key_onehot;
    key_code             = CODE_W'(onehot_to_bin(cand_ext));
  end

  state_e            state_q;
  logic [CODE_W-1:0] d_q;
  logic              loadn_q;

  // A chord parks in HELD without loading so it still needs a full release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      loadn_q <= 1'b1;
    end else begin
      loadn_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (stable) begin
            if (key_multi) begin
              state_q <= HELD;
            end else if (key_onehot && !enablen) begin
              d_q     <= key_code;
              loadn_q <= 1'b0;
              state_q <= HELD;
            end
          end
        end
        HELD: begin
          if (stable && !key_any) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              p_tick_q, p_tick_d;
  logic              wrap;

  always_comb begin
    wrap       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = wrap ? '0 : tick_cnt_q + 1'b1;
    p_tick_d   = (TICK_MODE == 1) ? (p_tick_q ^ wrap) : wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      p_tick_q   <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      p_tick_q   <= p_tick_d;
    end
  end

  assign D      = d_q;
  assign loadn  = loadn_q;
  assign p_tick = p_tick_q;

endmodule

// File: tb/tb_entrada_clock_param.sv
// Scoreboard bench: expected strobes (digit + edge) are queued at stimulus time.
module tb_entrada_clock_param;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] keyboard = '0;
  logic       enablen = 1'b1;

  logic [3:0] d0, d1;
  logic       loadn0, loadn1, tick0, tick1;

  entrada_clock_param #(
    .N_KEYS(10), .CODE_W(4), .DEBOUNCE_CYCLES(4), .CLK_DIV(DIV), .TICK_MODE(0)
  ) dut (
    .clk(clk), .rst(rst), .keyboard(keyboard), .enablen(enablen),
    .D(d0), .loadn(loadn0), .p_tick(tick0)
  );

  entrada_clock_param #(
    .N_KEYS(10), .CODE_W(4), .DEBOUNCE_CYCLES(4), .CLK_DIV(DIV), .TICK_MODE(1)
  ) dut_sq (
    .clk(clk), .rst(rst), .keyboard(keyboard), .enablen(enablen),
    .D(d1), .loadn(loadn1), .p_tick(tick1)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] d;
    int         edge_n;
  } exp_t;

  exp_t exp_q[$];
  bit   prev_low = 1'b0;

  // Strobe monitor: every low loadn must match the head of the queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_low = 1'b0;
    end else if (loadn0 === 1'b0) begin
      vectors++;
      if (prev_low) begin
        miscompares++;
        $display("FAIL strobe_width: loadn low again at edge %0d, required high", edge_cnt);
      end
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: edge %0d D=%0d, required no strobe", edge_cnt, d0);
      end else begin
        e = exp_q.pop_front();
        if (d0 !== e.d || edge_cnt != e.edge_n) begin
          miscompares++;
          $display("FAIL strobe: D=%0d at edge %0d, required D=%0d at edge %0d",
                   d0, edge_cnt, e.d, e.edge_n);
        end
      end
      prev_low = 1'b1;
    end else begin
      prev_low = 1'b0;
    end
  end

  task automatic set_keys(input logic [9:0] kb, output int k);
    @(posedge clk);
    #1;
    keyboard = kb;
    k = edge_cnt;
  endtask

  task automatic test_reset(output int r);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (d0 !== 4'd0 || loadn0 !== 1'b1 || tick0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mode0: D=%0d loadn=%b p_tick=%b, required 0 1 0", d0, loadn0, tick0);
    end
    vectors++;
    if (d1 !== 4'd0 || loadn1 !== 1'b1 || tick1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mode1: D=%0d loadn=%b p_tick=%b, required 0 1 0", d1, loadn1, tick1);
    end
    rst = 1'b0;
    r = edge_cnt;
  endtask

  task automatic test_tick(input int r);
    int  rel;
    logic exp0, exp1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rel  = edge_cnt - r;
      exp0 = ((rel % DIV) == 0);
      exp1 = (((rel / DIV) % 2) == 1);
      vectors++;
      if (tick0 !== exp0) begin
        miscompares++;
        $display("FAIL tick_pulse: edge %0d p_tick=%b, required %b", rel, tick0, exp0);
      end
      vectors++;
      if (tick1 !== exp1) begin
        miscompares++;
        $display("FAIL tick_square: edge %0d p_tick=%b, required %b", rel, tick1, exp1);
      end
    end
  endtask

  task automatic test_single_key();
    int k;
    enablen = 1'b0;
    set_keys(10'b10_0000_0000, k);
    exp_q.push_back('{d: 4'd9, edge_n: k + 8});
    repeat (20) @(posedge clk);
    set_keys('0, k);
    repeat (12) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (d0 !== 4'd9 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL single_key: D=%0d pending=%0d, required D=9 pending=0", d0, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_release_repress();
    int k;
    set_keys(10'b01_0000_0000, k);
    exp_q.push_back('{d: 4'd8, edge_n: k + 8});
    repeat (12) @(posedge clk);
    set_keys('0, k);
    repeat (12) @(posedge clk);
    set_keys(10'b00_0000_1000, k);
    exp_q.push_back('{d: 4'd3, edge_n: k + 8});
    repeat (12) @(posedge clk);
    set_keys('0, k);
    repeat (12) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (d0 !== 4'd3 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL release_repress: D=%0d pending=%0d, required D=3 pending=0", d0, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_bounce();
    int k;
    for (int t = 0; t < 5; t++) begin
      set_keys((t % 2 == 0) ? 10'b00_0010_0000 : 10'b0, k);
      if (t < 4) @(posedge clk);
    end
    exp_q.push_back('{d: 4'd5, edge_n: k + 8});
    repeat (16) @(posedge clk);
    set_keys('0, k);
    repeat (12) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (d0 !== 4'd5 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bounce: D=%0d pending=%0d, required D=5 pending=0", d0, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_chord_enable();
    int k;
    set_keys(10'b00_0000_0011, k);
    repeat (16) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (d0 !== 4'd5) begin
      miscompares++;
      $display("FAIL chord: D=%0d, required 5", d0);
    end
    set_keys('0, k);
    repeat (12) @(posedge clk);
    #1 enablen = 1'b1;
    set_keys(10'b00_0000_0100, k);
    repeat (16) @(posedge clk);
    #1 enablen = 1'b0;
    k = edge_cnt;
    exp_q.push_back('{d: 4'd2, edge_n: k + 1});
    repeat (6) @(posedge clk);
    #1 enablen = 1'b1;
    repeat (3) @(posedge clk);
    #1 enablen = 1'b0;
    repeat (6) @(posedge clk);
    set_keys('0, k);
    repeat (12) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (d0 !== 4'd2 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL enable_fall: D=%0d pending=%0d, required D=2 pending=0", d0, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_press();
    int k, r;
    set_keys(10'b00_1000_0000, k);
    exp_q.push_back('{d: 4'd7, edge_n: k + 8});
    repeat (12) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL press_before_reset: pending=%0d, required 0", exp_q.size());
    end
    exp_q.delete();
    rst = 1'b1;
    #1;
    vectors++;
    if (d0 !== 4'd0 || loadn0 !== 1'b1 || tick0 !== 1'b0 || tick1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: D=%0d loadn=%b p_tick=%b/%b, required 0 1 0/0",
               d0, loadn0, tick0, tick1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r = edge_cnt;
    exp_q.push_back('{d: 4'd7, edge_n: r + 8});
    repeat (16) @(posedge clk);
    set_keys('0, k);
    repeat (12) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (d0 !== 4'd7 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rekey_after_reset: D=%0d pending=%0d, required D=7 pending=0", d0, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    int r;
    test_reset(r);
    test_tick(r);
    test_single_key();
    test_release_repress();
    test_bounce();
    test_chord_enable();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
